// File: rtl/serial_rx_deframer_if.sv
// Receive-side link bundle: the strobed serial line from the transmitter, the
// valid/ack byte interface to the consumer, and the status flags.
interface serial_rx_deframer_if;
  logic       serial_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       dsr;
  logic       frame_error;
  logic       overrun;

  modport master (
    output serial_in,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  dsr,
    input  frame_error,
    input  overrun
  );

  modport slave (
    input  serial_in,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output dsr,
    output frame_error,
    output overrun
  );
endinterface

// File: rtl/serial_rx_deframer.sv
// Rebuilds 8-bit samples from the transmitter's strobed serial line, checks the
// stop bit, and hands bytes to the consumer over valid/ack with dsr flow control.
//
// state | meaning
// IDLE  | line idle; a 0 is the start strobe
// DATA  | counting bit periods, sampling 8 data bits MSB first
// STOP  | counting one more period, sampling the stop bit
module serial_rx_deframer #(
  parameter int BIT_PERIOD = 106,
  parameter int CNT_W      = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  serial_rx_deframer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q;
  logic              dsr_q;
  logic              frame_error_q;
  logic              overrun_q;

  logic              strobe;
  logic              commit;

  assign strobe = (cnt == CNT_LAST);
  assign commit = (state == STOP) && strobe && bus.serial_in;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      dsr_q         <= 1'b1;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.serial_in) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (strobe) begin
            cnt     <= '0;
            shift   <= {shift[6:0], bus.serial_in};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (strobe) begin
            cnt   <= '0;
            state <= IDLE;
            if (!bus.serial_in) frame_error_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // A commit with a same-edge ack replaces the unread byte; without ack it is dropped.
      if (commit) begin
        if (!rx_valid_q || bus.rx_ack) begin
          rx_data_q  <= shift;
          rx_valid_q <= 1'b1;
          dsr_q      <= 1'b0;
          overrun_q  <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ack) begin
        rx_valid_q <= 1'b0;
        dsr_q      <= 1'b1;
        overrun_q  <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.dsr         = dsr_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Bench for serial_rx_deframer: table of single frames plus hand-written
// overrun, same-edge ack and mid-frame reset sequences, with an output scoreboard.
module tb_serial_rx_deframer;

  localparam int BP = 106;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  serial_rx_deframer_if bus();

  serial_rx_deframer #(.BIT_PERIOD(BP), .CNT_W(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [7:0] din;
    logic       stop;
    bit         glitch;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  vec_t vecs[7];
  ev_t  sbq[$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit glitch, input bit ack_stop);
    bus.serial_in = 1'b0;
    tick();
    for (int n = 1; n <= 9; n++) begin
      for (int c = 1; c <= BP; c++) begin
        if (c == BP) begin
          if (n == 9) begin
            bus.serial_in = stop_bit;
            if (ack_stop) bus.rx_ack = 1'b1;
          end else begin
            bus.serial_in = b[8-n];
          end
        end else begin
          bus.serial_in = (glitch && (c == 1 || c == 50 || c == BP - 1)) ? 1'b0 : 1'b1;
        end
        tick();
      end
    end
    bus.serial_in = 1'b1;
    bus.rx_ack    = 1'b0;
  endtask

  task automatic do_ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
  endtask

  task automatic chk_out(string tag, logic [7:0] d, logic v, logic fe, logic ov);
    chk({tag, "_data"}, bus.rx_data, d);
    chk({tag, "_valid"}, bus.rx_valid, v);
    chk({tag, "_dsr"}, bus.dsr, !v);
    chk({tag, "_ferr"}, bus.frame_error, fe);
    chk({tag, "_ovr"}, bus.overrun, ov);
  endtask

  // Output monitor: every new byte or framing error must match the next queued expectation.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clock) begin
    ev_t e;
    if (reset_n && (bus.frame_error ||
        (bus.rx_valid && (!prev_valid || bus.rx_data != prev_data)))) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got ferr=%0b data=0x%0h with nothing expected at %0t",
                 bus.frame_error, bus.rx_data, $time);
      end else begin
        e = sbq.pop_front();
        chk("sb_kind", bus.frame_error, e.err);
        if (!e.err) chk("sb_data", bus.rx_data, e.data);
      end
    end
    prev_valid = bus.rx_valid;
    prev_data  = bus.rx_data;
  end

  initial begin
    ev_t ev;
    vecs[0] = '{din: 8'hA5, stop: 1'b0, glitch: 1'b0, exp_data: 8'h00, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[1] = '{din: 8'hA5, stop: 1'b1, glitch: 1'b0, exp_data: 8'hA5, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{din: 8'h00, stop: 1'b1, glitch: 1'b1, exp_data: 8'h00, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{din: 8'h3C, stop: 1'b1, glitch: 1'b1, exp_data: 8'h3C, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{din: 8'hC3, stop: 1'b0, glitch: 1'b0, exp_data: 8'h3C, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[5] = '{din: 8'hFF, stop: 1'b1, glitch: 1'b0, exp_data: 8'hFF, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[6] = '{din: 8'h81, stop: 1'b1, glitch: 1'b0, exp_data: 8'h81, exp_valid: 1'b1, exp_ferr: 1'b0};

    bus.serial_in = 1'b1;
    bus.rx_ack    = 1'b0;
    reset_n       = 1'b0;
    tick();
    tick();
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (20) tick();
    chk_out("idle_high", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      ev.err  = vecs[i].exp_ferr;
      ev.data = vecs[i].din;
      sbq.push_back(ev);
      send_frame(vecs[i].din, vecs[i].stop, vecs[i].glitch, 1'b0);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_ferr, 1'b0);
      tick();
      chk($sformatf("vec%0d_fe_pulse", i), bus.frame_error, 0);
      if (vecs[i].exp_valid) begin
        do_ack();
        chk($sformatf("vec%0d_ack_valid", i), bus.rx_valid, 0);
        chk($sformatf("vec%0d_ack_dsr", i), bus.dsr, 1);
      end
      repeat (3) tick();
    end

    // Back-to-back frames without ack: second byte dropped, overrun raised.
    ev.err = 1'b0; ev.data = 8'h3C; sbq.push_back(ev);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk_out("ovr_first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    chk_out("ovr_second", 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (5) tick();
    chk("ovr_sticky", bus.overrun, 1);
    do_ack();
    chk_out("ovr_ack", 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Ack landing on the commit edge of the next frame.
    ev.data = 8'h3C; sbq.push_back(ev);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    ev.data = 8'h81; sbq.push_back(ev);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    chk_out("ack_commit", 8'h81, 1'b1, 1'b0, 1'b0);
    do_ack();
    chk_out("ack_commit_clr", 8'h81, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset one edge at S+400 of a 0xFF frame; nothing may come out of it.
    bus.serial_in = 1'b0;
    tick();
    bus.serial_in = 1'b1;
    repeat (399) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (700) tick();
    chk_out("midreset_quiet", 8'h00, 1'b0, 1'b0, 1'b0);
    ev.data = 8'h12; sbq.push_back(ev);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    chk_out("after_reset", 8'h12, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
